model1_seq_ctrl: RTL and testbench

- Sequencer that drives the model1 serial detector.
- Accepts a parallel word over a valid/ready handshake and shifts it onto sel MSB-first, one bit per clk.
- Counts flag pulses returned by model1 inside a latency-aligned window, then returns the hit count over a second valid/ready handshake.
- Sits between the stimulus/host side and the model1 datapath. It is the only driver of sel.

---
 rtl/model1_pkg.sv | 19 +
 rtl/model1_shifter.sv | 48 ++++
 rtl/model1_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_model1_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model1_pkg.sv
// Shared types and constants for the model1 sequencer.
package model1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } model1_ctrl_state_e;

    localparam int MODEL1_DATA_W   = 8;
    localparam int MODEL1_FLAG_LAT = 1;

    // Smallest hit-counter width that can hold a count of data_w hits.
    function automatic int model1_min_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/model1_shifter.sv
// Loadable MSB-first shift register with bit counter and done strobe.
// bit_out is registered; it shows the loaded MSB the cycle after load and
// returns to 0 once the last bit has been presented.
module model1_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic              bit_out,
    output logic              done
);
    localparam int BCNT_W = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sreg_r;
    logic [BCNT_W-1:0] bcnt_r;
    logic              bit_r;

    assign bit_out = bit_r;
    assign done    = shift && (bcnt_r == BCNT_LAST);

    // Load the word, then present one bit per shift cycle, MSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_r <= '0;
            bcnt_r <= '0;
            bit_r  <= 1'b0;
        end else if (load) begin
            bit_r  <= data[DATA_W-1];
            sreg_r <= {data[DATA_W-2:0], 1'b0};
            bcnt_r <= '0;
        end else if (shift) begin
            if (bcnt_r == BCNT_LAST) begin
                bit_r <= 1'b0;
            end else begin
                bit_r  <= sreg_r[DATA_W-1];
                sreg_r <= {sreg_r[DATA_W-2:0], 1'b0};
                bcnt_r <= bcnt_r + BCNT_W'(1);
            end
        end else begin
            bit_r <= 1'b0;
        end
    end

endmodule

// File: rtl/model1_seq_ctrl.sv
// Sequencer for the model1 serial detector: serialises a word onto sel,
// counts flag pulses in a latency-aligned window and returns the count.
// Optional macro MODEL1_SEQ_CTRL_POS_EN adds out_first_pos (bit index of the
// first flagged bit, all-ones when no hit).
module model1_seq_ctrl
    import model1_pkg::*;
#(
    parameter int DATA_W   = MODEL1_DATA_W,
    parameter int CNT_W    = model1_min_cnt_w(DATA_W),
    parameter int FLAG_LAT = MODEL1_FLAG_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sel,
    input  logic              flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_hits,
`ifdef MODEL1_SEQ_CTRL_POS_EN
    output logic [CNT_W-1:0]  out_first_pos,
`endif
    output logic              busy
);
    // Window counter spans SHIFT and DRAIN: t = 0 .. DATA_W+FLAG_LAT-1.
    localparam int WIN_W = $clog2(DATA_W + FLAG_LAT + 1);
    localparam logic [WIN_W-1:0] WIN_FIRST = WIN_W'(FLAG_LAT);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(DATA_W + FLAG_LAT - 1);
    localparam logic [CNT_W-1:0] HITS_MAX  = '1;

    model1_ctrl_state_e state_r, state_s;
    logic               accept_s, shift_s, done_s, in_win_s, hit_s;
    logic [WIN_W-1:0]   win_r;
    logic [CNT_W-1:0]   hits_r, hits_s, out_hits_r;
    logic               in_ready_r, out_valid_r, busy_r;

    assign accept_s  = (state_r == IDLE) && in_valid;
    assign shift_s   = (state_r == SHIFT);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_hits  = out_hits_r;
    assign busy      = busy_r;

    model1_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_s),
        .shift   (shift_s),
        .data    (in_data),
        .bit_out (sel),
        .done    (done_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)           state_s = SHIFT; else state_s = IDLE;
            SHIFT:   if (done_s)             state_s = DRAIN; else state_s = SHIFT;
            DRAIN:   if (win_r == WIN_LAST)  state_s = RESP;  else state_s = DRAIN;
            RESP:    if (out_ready)          state_s = IDLE;  else state_s = RESP;
            default:                         state_s = IDLE;
        endcase
    end

    // Flag window qualification and saturating hit increment.
    always_comb begin
        in_win_s = 1'b0;
        hits_s   = hits_r;
        if ((state_r == SHIFT || state_r == DRAIN) && (win_r >= WIN_FIRST)) begin
            in_win_s = 1'b1;
        end else begin
            in_win_s = 1'b0;
        end
        hit_s = in_win_s && flag;
        if (hit_s && (hits_r != HITS_MAX)) begin
            hits_s = hits_r + CNT_W'(1);
        end else begin
            hits_s = hits_r;
        end
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == RESP);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Window and hit counters: cleared on accept, advanced through SHIFT/DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_r  <= '0;
            hits_r <= '0;
        end else if (accept_s) begin
            win_r  <= '0;
            hits_r <= '0;
        end else if (state_r == SHIFT || state_r == DRAIN) begin
            win_r  <= win_r + WIN_W'(1);
            hits_r <= hits_s;
        end
    end

    // Capture the final count (including the last window slot) on RESP entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_hits_r <= '0;
        end else if (state_r == DRAIN && state_s == RESP) begin
            out_hits_r <= hits_s;
        end
    end

`ifdef MODEL1_SEQ_CTRL_POS_EN
    logic [CNT_W-1:0] pos_r, pos_s, out_pos_r;
    logic [WIN_W-1:0] slot_s;

    assign out_first_pos = out_pos_r;

    // Bit index of the window slot that produced the first hit.
    always_comb begin
        slot_s = win_r - WIN_FIRST;
        pos_s  = pos_r;
        if (hit_s && (hits_r == '0)) begin
            pos_s = CNT_W'(slot_s);
        end else begin
            pos_s = pos_r;
        end
    end

    // First-hit position tracking and its RESP-entry capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_r     <= '1;
            out_pos_r <= '1;
        end else begin
            if (accept_s) begin
                pos_r <= '1;
            end else if (state_r == SHIFT || state_r == DRAIN) begin
                pos_r <= pos_s;
            end
            if (state_r == DRAIN && state_s == RESP) begin
                out_pos_r <= pos_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_model1_seq_ctrl.sv
// Scoreboard bench for model1_seq_ctrl: a FLAG_LAT=1 instance with a
// one-cycle echo stub and a FLAG_LAT=3 instance with a three-cycle echo stub.
module tb_model1_seq_ctrl;

    typedef struct packed {
        logic [3:0] hits;
        logic [3:0] pos;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    // Instance with FLAG_LAT = 1
    logic       in_valid = 1'b0, in_ready, sel, flag, out_valid, busy;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [3:0] out_hits;
    logic       flag_d1 = 1'b0;
    logic       force_flag = 1'b0;
    logic       rnd_ready = 1'b0;

    // Instance with FLAG_LAT = 3
    logic       in_valid3 = 1'b0, in_ready3, sel3, flag3, out_valid3, busy3;
    logic       out_ready3 = 1'b1;
    logic [7:0] in_data3 = 8'h00;
    logic [3:0] out_hits3;
    logic [2:0] d3 = 3'b000;

`ifdef MODEL1_SEQ_CTRL_POS_EN
    logic [3:0] pos1, pos3;
`endif

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flag stubs: echo sel one (resp. three) cycles late.
    always @(posedge clk) begin
        flag_d1 <= sel;
        d3      <= {d3[1:0], sel3};
    end
    assign flag  = flag_d1 | force_flag;
    assign flag3 = d3[2];

    model1_seq_ctrl #(.DATA_W(8), .CNT_W(4), .FLAG_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel(sel), .flag(flag), .out_valid(out_valid),
        .out_ready(out_ready), .out_hits(out_hits),
`ifdef MODEL1_SEQ_CTRL_POS_EN
        .out_first_pos(pos1),
`endif
        .busy(busy)
    );

    model1_seq_ctrl #(.DATA_W(8), .CNT_W(4), .FLAG_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .sel(sel3), .flag(flag3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_hits(out_hits3),
`ifdef MODEL1_SEQ_CTRL_POS_EN
        .out_first_pos(pos3),
`endif
        .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: with an echo stub every transmitted 1 comes back once inside
    // the window; a permanently high flag hits every window slot.
    function automatic exp_t model(input logic [7:0] d, input bit forced);
        exp_t e;
        bit   found;
        e.hits = forced ? 4'd8 : 4'($countones(d));
        e.pos  = 4'hF;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (forced || d[7-i])) begin
                e.pos = 4'(i);
                found = 1'b1;
            end
        end
        return e;
    endfunction

    // Present a word, wait (bounded) for acceptance, optionally log the expectation.
    task automatic send(input bit w3, input logic [7:0] d, input bit push, output int acc);
        int n;
        @(posedge clk); #1;
        if (w3) begin in_valid3 = 1'b1; in_data3 = d; end
        else    begin in_valid  = 1'b1; in_data  = d; end
        n = 0;
        while (((w3 ? in_ready3 : in_ready) !== 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        acc = cyc;
        if (push) begin
            if (w3) q3.push_back(model(d, 1'b0));
            else    q1.push_back(model(d, force_flag));
        end
    endtask

    task automatic drop_valid();
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(q1.size() + q3.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor for the FLAG_LAT=1 instance.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q1.size() == 0) begin
                chk("unexpected_resp", 32'(q1.size()), 32'd1);
            end else begin
                chk("out_hits", 32'(out_hits), 32'(q1[0].hits));
`ifdef MODEL1_SEQ_CTRL_POS_EN
                chk("out_first_pos", 32'(pos1), 32'(q1[0].pos));
`endif
                chk("sel_in_resp", 32'(sel), 32'd0);
                chk("in_ready_in_resp", 32'(in_ready), 32'd0);
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    // Monitor for the FLAG_LAT=3 instance.
    always @(negedge clk) begin
        if (rst_n && out_valid3) begin
            if (q3.size() == 0) begin
                chk("unexpected_resp3", 32'(q3.size()), 32'd1);
            end else begin
                chk("out_hits3", 32'(out_hits3), 32'(q3[0].hits));
`ifdef MODEL1_SEQ_CTRL_POS_EN
                chk("out_first_pos3", 32'(pos3), 32'(q3[0].pos));
`endif
                if (out_ready3) void'(q3.pop_front());
            end
        end
    end

    // Randomised consumer backpressure, changed just after the active edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, n;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_hits", 32'(out_hits), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef MODEL1_SEQ_CTRL_POS_EN
        chk("rst_first_pos", 32'(pos1), 32'hF);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic serialisation of 8'hA5 with cycle-exact sel and out_valid.
        d = 8'hA5;
        send(1'b0, d, 1'b1, a0);
        drop_valid();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sel_bit", 32'(sel), 32'(d[7-i]));
            chk("busy_shift", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("drain_sel", 32'(sel), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("out_valid_cycle10", 32'(out_valid), 32'd1);
        drain();

        // Saturation: flag forced high across IDLE, window and RESP.
        force_flag = 1'b1;
        send(1'b0, 8'hFF, 1'b1, a0);
        drop_valid();
        drain();
        send(1'b0, 8'h00, 1'b1, a0);
        drop_valid();
        drain();
        force_flag = 1'b0;
        repeat (2) @(posedge clk);

        // Backpressure: five cycles of out_ready low in RESP.
        out_ready = 1'b0;
        send(1'b0, 8'h3C, 1'b1, a0);
        drop_valid();
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("resp_reached", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hits", 32'(out_hits), 32'd4);
            chk("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid held: minimum turnaround between accepts.
        send(1'b0, 8'h0F, 1'b1, a0);
        send(1'b0, 8'hF0, 1'b1, a1);
        drop_valid();
        chk("turnaround", 32'(a1 - a0), 32'd11);
        drain();

        // Reset in SHIFT at t=3 aborts the word without a response.
        send(1'b0, 8'hFF, 1'b0, a0);
        drop_valid();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(1'b0, 8'h01, 1'b1, a0);
        drop_valid();
        drain();

        // Random words with random gaps and random consumer backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(1'b0, 8'($urandom), 1'b1, a0);
            drop_valid();
        end
        drain();
        rnd_ready = 1'b0;
        #1 out_ready = 1'b1;
        drain();

        // FLAG_LAT = 3 instance with a three-cycle stub.
        send(1'b1, 8'h81, 1'b1, a0);
        drop_valid();
        drain();
        for (int k = 0; k < 6; k++) begin
            send(1'b1, 8'($urandom), 1'b1, a0);
            drop_valid();
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
